// File: rtl/prbs_link_test_ctrl_if.sv
// Control/status bundle between the ILA/VIO side and the PRBS7 link-test sequencer.
// The master drives the run controls and the aligner status; the slave (sequencer) returns the link resets and the results.
interface prbs_link_test_ctrl_if;
  logic        start;
  logic        abort;
  logic        aligned;
  logic [5:0]  err_cnt;
  logic        tx_rst_n;
  logic        rx_rst_n;
  logic        prbs_dis;
  logic        busy;
  logic        done;
  logic        pass;
  logic        align_lost;
  logic [1:0]  retries;
  logic [31:0] err_total;
  logic [31:0] word_total;

  modport master (
    output start, abort, aligned, err_cnt,
    input  tx_rst_n, rx_rst_n, prbs_dis, busy, done, pass, align_lost,
           retries, err_total, word_total
  );

  modport slave (
    input  start, abort, aligned, err_cnt,
    output tx_rst_n, rx_rst_n, prbs_dis, busy, done, pass, align_lost,
           retries, err_total, word_total
  );
endinterface

// File: rtl/prbs_link_test_ctrl.sv
// Sequences one PRBS7 link-test run: generator reset, aligner reset with retries,
// then error accumulation over a fixed window of aligned words.
module prbs_link_test_ctrl #(
  parameter int unsigned TX_RST_CYC    = 16,
  parameter int unsigned RX_RST_CYC    = 16,
  parameter int unsigned ALIGN_TIMEOUT = 4096,
  parameter int unsigned WINDOW        = 1048576,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned ERR_LIMIT     = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  prbs_link_test_ctrl_if.slave      bus
);

  localparam int unsigned RST_CYC_MAX = (TX_RST_CYC > RX_RST_CYC) ? TX_RST_CYC : RX_RST_CYC;
  localparam int unsigned CNT_W       = $clog2(RST_CYC_MAX + 1);
  localparam int unsigned TMO_W       = $clog2(ALIGN_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_TX_RST, S_RX_RST, S_WAIT_ALIGN, S_MEASURE, S_DONE, S_FAIL
  } state_t;

  state_t         state;
  logic [CNT_W-1:0] cnt;
  logic [TMO_W-1:0] tmo;
  logic [5:0]     last_err;
  logic           tx_rst_n_q, rx_rst_n_q, prbs_dis_q, busy_q, done_q, pass_q, align_lost_q;
  logic [1:0]     retries_q;
  logic [31:0]    err_total_q, word_total_q;

  // Per-word error delta; the mod-64 subtract absorbs err_cnt wrap.
  logic [5:0]  delta;
  logic [32:0] err_sum;
  logic [31:0] err_next, word_next;

  assign delta     = bus.err_cnt - last_err;
  assign err_sum   = {1'b0, err_total_q} + 33'(delta);
  assign err_next  = err_sum[32] ? 32'hFFFF_FFFF : err_sum[31:0];
  assign word_next = word_total_q + 32'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      tmo          <= '0;
      last_err     <= '0;
      tx_rst_n_q   <= 1'b0;
      rx_rst_n_q   <= 1'b0;
      prbs_dis_q   <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      align_lost_q <= 1'b0;
      retries_q    <= '0;
      err_total_q  <= '0;
      word_total_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (bus.abort) begin
        state      <= S_IDLE;
        tx_rst_n_q <= 1'b1;
        rx_rst_n_q <= 1'b1;
        prbs_dis_q <= 1'b1;
        busy_q     <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE, S_DONE, S_FAIL: begin
            tx_rst_n_q <= 1'b1;
            rx_rst_n_q <= 1'b1;
            prbs_dis_q <= 1'b1;
            if (bus.start) begin
              state        <= S_TX_RST;
              tx_rst_n_q   <= 1'b0;
              prbs_dis_q   <= 1'b0;
              busy_q       <= 1'b1;
              cnt          <= '0;
              retries_q    <= '0;
              pass_q       <= 1'b0;
              align_lost_q <= 1'b0;
              err_total_q  <= '0;
              word_total_q <= '0;
            end
          end
          S_TX_RST: begin
            if (cnt == CNT_W'(TX_RST_CYC - 1)) begin
              state      <= S_RX_RST;
              tx_rst_n_q <= 1'b1;
              rx_rst_n_q <= 1'b0;
              cnt        <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          S_RX_RST: begin
            if (cnt == CNT_W'(RX_RST_CYC - 1)) begin
              state      <= S_WAIT_ALIGN;
              rx_rst_n_q <= 1'b1;
              tmo        <= TMO_W'(ALIGN_TIMEOUT - 1);
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          S_WAIT_ALIGN: begin
            if (bus.aligned) begin
              state    <= S_MEASURE;
              last_err <= bus.err_cnt;
            end else if (tmo == '0) begin
              if (retries_q < 2'(MAX_RETRY)) begin
                state      <= S_RX_RST;
                retries_q  <= retries_q + 2'd1;
                rx_rst_n_q <= 1'b0;
                cnt        <= '0;
              end else begin
                state      <= S_FAIL;
                busy_q     <= 1'b0;
                done_q     <= 1'b1;
                pass_q     <= 1'b0;
                prbs_dis_q <= 1'b1;
              end
            end else begin
              tmo <= tmo - TMO_W'(1);
            end
          end
          S_MEASURE: begin
            if (!bus.aligned) begin
              state        <= S_FAIL;
              align_lost_q <= 1'b1;
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
              pass_q       <= 1'b0;
              prbs_dis_q   <= 1'b1;
            end else begin
              word_total_q <= word_next;
              err_total_q  <= err_next;
              last_err     <= bus.err_cnt;
              // Final word's delta is folded into the pass decision.
              if (word_next == 32'(WINDOW)) begin
                state      <= S_DONE;
                busy_q     <= 1'b0;
                done_q     <= 1'b1;
                pass_q     <= (err_next <= 32'(ERR_LIMIT));
                prbs_dis_q <= 1'b1;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.tx_rst_n   = tx_rst_n_q;
  assign bus.rx_rst_n   = rx_rst_n_q;
  assign bus.prbs_dis   = prbs_dis_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.align_lost = align_lost_q;
  assign bus.retries    = retries_q;
  assign bus.err_total  = err_total_q;
  assign bus.word_total = word_total_q;

endmodule

// File: tb/tb_prbs_link_test_ctrl.sv
// Directed bench for prbs_link_test_ctrl; uses a shortened measurement window.
module tb_prbs_link_test_ctrl;
  localparam int unsigned TB_WINDOW = 1024;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  prbs_link_test_ctrl_if bus();

  prbs_link_test_ctrl #(
    .TX_RST_CYC(16), .RX_RST_CYC(16), .ALIGN_TIMEOUT(4096),
    .WINDOW(TB_WINDOW), .MAX_RETRY(3), .ERR_LIMIT(0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_rx_release(output bit ok);
    bit seen_low;
    seen_low = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!seen_low && bus.rx_rst_n === 1'b0) seen_low = 1'b1;
      else if (seen_low && bus.rx_rst_n === 1'b1) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic wait_done(input int budget, output int cyc, output bit ok);
    cyc = 0;
    ok = 1'b0;
    while (cyc < budget) begin
      tick();
      cyc++;
      if (bus.done === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (bus.tx_rst_n !== 1'b0) begin fails++; $display("FAIL rst_tx_rst_n got=%0b exp=0", bus.tx_rst_n); end
    tests++; if (bus.rx_rst_n !== 1'b0) begin fails++; $display("FAIL rst_rx_rst_n got=%0b exp=0", bus.rx_rst_n); end
    tests++; if (bus.prbs_dis !== 1'b1) begin fails++; $display("FAIL rst_prbs_dis got=%0b exp=1", bus.prbs_dis); end
    tests++; if ({bus.busy, bus.done, bus.pass, bus.align_lost} !== 4'b0000) begin fails++;
      $display("FAIL rst_flags got=%b exp=0000", {bus.busy, bus.done, bus.pass, bus.align_lost}); end
    tests++; if ({bus.retries, bus.err_total, bus.word_total} !== 66'd0) begin fails++;
      $display("FAIL rst_counters got=%0d/%0d/%0d exp=0/0/0", bus.retries, bus.err_total, bus.word_total); end
    reset = 1'b1;
    tick();
    tests++; if ({bus.tx_rst_n, bus.rx_rst_n, bus.prbs_dis, bus.busy} !== 4'b1110) begin fails++;
      $display("FAIL idle_outputs got=%b exp=1110", {bus.tx_rst_n, bus.rx_rst_n, bus.prbs_dis, bus.busy}); end
  endtask

  task automatic test_clean();
    bit ok;
    int cyc;
    bus.err_cnt = 6'd5;
    bus.aligned = 1'b0;
    pulse_start();
    tests++; if ({bus.busy, bus.tx_rst_n, bus.prbs_dis} !== 3'b100) begin fails++;
      $display("FAIL t1_tx_rst_entry got=%b exp=100", {bus.busy, bus.tx_rst_n, bus.prbs_dis}); end
    wait_rx_release(ok);
    tests++; if (!ok) begin fails++; $display("FAIL t1_rx_release got=timeout exp=release"); end
    repeat (99) tick();
    bus.aligned = 1'b1;
    wait_done(2000, cyc, ok);
    tests++; if (!ok) begin fails++; $display("FAIL t1_done got=timeout exp=done"); end
    tests++; if (bus.pass !== 1'b1) begin fails++; $display("FAIL t1_pass got=%0b exp=1", bus.pass); end
    tests++; if (bus.word_total !== 32'(TB_WINDOW)) begin fails++; $display("FAIL t1_word_total got=%0d exp=%0d", bus.word_total, TB_WINDOW); end
    tests++; if (bus.err_total !== 32'd0) begin fails++; $display("FAIL t1_err_total got=%0d exp=0", bus.err_total); end
    tests++; if (bus.retries !== 2'd0) begin fails++; $display("FAIL t1_retries got=%0d exp=0", bus.retries); end
    tests++; if ({bus.busy, bus.prbs_dis, bus.align_lost} !== 3'b010) begin fails++;
      $display("FAIL t1_done_state got=%b exp=010", {bus.busy, bus.prbs_dis, bus.align_lost}); end
    tick();
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL t1_done_pulse_width got=%0b exp=0", bus.done); end
    bus.aligned = 1'b0;
  endtask

  task automatic test_err_wrap();
    bit ok;
    int cyc;
    int ndone;
    bus.err_cnt = 6'd60;
    pulse_start();
    tests++; if ({bus.word_total, bus.err_total, 1'b0, bus.pass} !== 66'd0) begin fails++;
      $display("FAIL t2_restart_clear got=%0d/%0d/%0b exp=0/0/0", bus.word_total, bus.err_total, bus.pass); end
    wait_rx_release(ok);
    tests++; if (!ok) begin fails++; $display("FAIL t2_rx_release got=timeout exp=release"); end
    repeat (10) tick();
    bus.aligned = 1'b1;
    tick();
    bus.err_cnt = 6'd63;
    tick();
    bus.err_cnt = 6'd2;
    tick();
    tests++; if (bus.err_total !== 32'd6) begin fails++; $display("FAIL t2_err_after_wrap got=%0d exp=6", bus.err_total); end
    wait_done(2000, cyc, ok);
    ndone = ok ? 1 : 0;
    repeat (20) begin tick(); if (bus.done === 1'b1) ndone++; end
    tests++; if (ndone != 1) begin fails++; $display("FAIL t2_done_pulses got=%0d exp=1", ndone); end
    tests++; if (bus.err_total !== 32'd6) begin fails++; $display("FAIL t2_err_total got=%0d exp=6", bus.err_total); end
    tests++; if (bus.pass !== 1'b0) begin fails++; $display("FAIL t2_pass got=%0b exp=0", bus.pass); end
    tests++; if (bus.word_total !== 32'(TB_WINDOW)) begin fails++; $display("FAIL t2_word_total got=%0d exp=%0d", bus.word_total, TB_WINDOW); end
    bus.aligned = 1'b0;
  endtask

  task automatic test_timeout();
    int cyc, run, pulses, bad;
    bit got;
    cyc = 0; run = 0; pulses = 0; bad = 0; got = 1'b0;
    bus.aligned = 1'b0;
    pulse_start();
    while (cyc < 20000 && !got) begin
      tick();
      cyc++;
      if (bus.rx_rst_n === 1'b0) run++;
      else if (run != 0) begin pulses++; if (run != 16) bad++; run = 0; end
      if (bus.done === 1'b1) got = 1'b1;
    end
    tests++; if (!got) begin fails++; $display("FAIL t3_done got=timeout exp=done"); end
    tests++; if (cyc < 16462 || cyc > 16466) begin fails++; $display("FAIL t3_done_time got=%0d exp=16464+/-2", cyc); end
    tests++; if (pulses != 4 || bad != 0) begin fails++; $display("FAIL t3_rx_pulses got=%0d(bad %0d) exp=4(bad 0)", pulses, bad); end
    tests++; if (bus.retries !== 2'd3) begin fails++; $display("FAIL t3_retries got=%0d exp=3", bus.retries); end
    tests++; if ({bus.pass, bus.busy, bus.prbs_dis} !== 3'b001) begin fails++;
      $display("FAIL t3_fail_state got=%b exp=001", {bus.pass, bus.busy, bus.prbs_dis}); end
  endtask

  task automatic test_lost_lock();
    bit ok;
    bus.err_cnt = 6'd0;
    pulse_start();
    wait_rx_release(ok);
    tests++; if (!ok) begin fails++; $display("FAIL t4_rx_release got=timeout exp=release"); end
    repeat (5) tick();
    bus.aligned = 1'b1;
    repeat (501) tick();
    bus.aligned = 1'b0;
    tick();
    tests++; if (bus.done !== 1'b1) begin fails++; $display("FAIL t4_done got=%0b exp=1", bus.done); end
    tests++; if (bus.align_lost !== 1'b1) begin fails++; $display("FAIL t4_align_lost got=%0b exp=1", bus.align_lost); end
    tests++; if (bus.word_total !== 32'd500) begin fails++; $display("FAIL t4_word_total got=%0d exp=500", bus.word_total); end
    tests++; if ({bus.pass, bus.busy} !== 2'b00) begin fails++; $display("FAIL t4_pass_busy got=%b exp=00", {bus.pass, bus.busy}); end
  endtask

  task automatic test_control();
    bit ok;
    // abort during MEASURE
    pulse_start();
    wait_rx_release(ok);
    tests++; if (!ok) begin fails++; $display("FAIL t5_rx_release got=timeout exp=release"); end
    bus.aligned = 1'b1;
    tick();
    repeat (10) tick();
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL t5_measure_busy got=%0b exp=1", bus.busy); end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.aligned = 1'b0;
    tests++; if ({bus.busy, bus.tx_rst_n, bus.rx_rst_n, bus.prbs_dis} !== 4'b0111) begin fails++;
      $display("FAIL t5_abort_idle got=%b exp=0111", {bus.busy, bus.tx_rst_n, bus.rx_rst_n, bus.prbs_dis}); end
    tests++; if (bus.word_total !== 32'd10) begin fails++; $display("FAIL t5_abort_hold got=%0d exp=10", bus.word_total); end
    // start while busy must not restart the generator reset
    pulse_start();
    repeat (5) tick();
    pulse_start();
    repeat (9) tick();
    tests++; if (bus.tx_rst_n !== 1'b0) begin fails++; $display("FAIL t5_tx_rst_len got=%0b exp=0", bus.tx_rst_n); end
    tick();
    tests++; if ({bus.tx_rst_n, bus.rx_rst_n} !== 2'b10) begin fails++;
      $display("FAIL t5_start_ignored got=%b exp=10", {bus.tx_rst_n, bus.rx_rst_n}); end
    // abort wins over start
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.start = 1'b0;
    tests++; if ({bus.busy, bus.tx_rst_n} !== 2'b01) begin fails++;
      $display("FAIL t5_abort_priority got=%b exp=01", {bus.busy, bus.tx_rst_n}); end
    // async reset in the middle of TX_RST
    pulse_start();
    repeat (3) tick();
    #2 reset = 1'b0;
    #1;
    tests++; if ({bus.tx_rst_n, bus.prbs_dis, bus.busy} !== 3'b010) begin fails++;
      $display("FAIL t5_async_reset got=%b exp=010", {bus.tx_rst_n, bus.prbs_dis, bus.busy}); end
    #3 reset = 1'b1;
    tick();
    tests++; if ({bus.tx_rst_n, bus.busy} !== 2'b10) begin fails++;
      $display("FAIL t5_post_reset_idle got=%b exp=10", {bus.tx_rst_n, bus.busy}); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.aligned = 1'b0;
    bus.err_cnt = 6'd0;
    reset = 1'b0;
    test_reset();
    test_clean();
    test_err_wrap();
    test_timeout();
    test_lost_lock();
    test_control();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
